// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter encoding
// and its saturating next-state function.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  localparam bp_ctr_t BP_CTR_RESET = WNT;

  function automatic bp_ctr_t bpCtrNext(input bp_ctr_t cur, input logic taken);
    bp_ctr_t nxt;
    nxt = cur;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating event counter with increment enable and synchronous
// active-low clear; holds at all-ones instead of wrapping.
module bp_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor: 2-bit direction counters plus BTB,
// combinational lookup from fetch, training from execute, perf counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PCF_i,
  output logic                  PredictTakenF_o,
  output logic [DATA_WIDTH-1:0] PredTargetF_o,
  input  logic                  BranchE_i,
  input  logic                  BranchTakenE_i,
  input  logic [DATA_WIDTH-1:0] PCE_i,
  input  logic [DATA_WIDTH-1:0] PCTargetE_i,
  input  logic                  PredictTakenE_i,
  output logic                  MispredictE_o,
  output logic [31:0]           BranchCount_o,
  output logic [31:0]           MispredCount_o
);

  localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS - 2;
  localparam int ENTRIES  = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]    validArr;
  bp_ctr_t               ctrArr    [ENTRIES];
  logic [TAG_BITS-1:0]   tagArr    [ENTRIES];
  logic [DATA_WIDTH-1:0] targetArr [ENTRIES];

  logic [INDEX_BITS-1:0] idxF, idxE;
  logic [TAG_BITS-1:0]   tagF, tagE;
  logic                  hitF, hitE, predictF;
  bp_ctr_t               ctrF;
  logic [DATA_WIDTH-1:0] targetF;
  logic                  unusedPcBits;

  assign idxF = PCF_i[INDEX_BITS+1:2];
  assign tagF = PCF_i[DATA_WIDTH-1:INDEX_BITS+2];
  assign idxE = PCE_i[INDEX_BITS+1:2];
  assign tagE = PCE_i[DATA_WIDTH-1:INDEX_BITS+2];
  assign unusedPcBits = ^{PCF_i[1:0], PCE_i[1:0]};

  // Compare-based mux so an unknown fetch PC selects nothing and the
  // prediction falls back to not-taken rather than propagating X.
  always_comb begin
    hitF    = 1'b0;
    ctrF    = SNT;
    targetF = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (idxF == INDEX_BITS'(i)) begin
        hitF    = validArr[i] && (tagArr[i] == tagF);
        ctrF    = ctrArr[i];
        targetF = targetArr[i];
      end
    end
  end

  assign predictF        = rst && hitF && ctrF[1];
  assign PredictTakenF_o = predictF;
  assign PredTargetF_o   = predictF ? targetF : '0;

  assign hitE          = validArr[idxE] && (tagArr[idxE] == tagE);
  assign MispredictE_o = rst && BranchE_i && (PredictTakenE_i != BranchTakenE_i);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validArr[i]  <= 1'b0;
        ctrArr[i]    <= BP_CTR_RESET;
        tagArr[i]    <= '0;
        targetArr[i] <= '0;
      end
    end else if (BranchE_i) begin
      if (hitE) begin
        ctrArr[idxE] <= bpCtrNext(ctrArr[idxE], BranchTakenE_i);
        if (BranchTakenE_i) begin
          targetArr[idxE] <= PCTargetE_i;
        end
      end else if (BranchTakenE_i) begin
        // Never-taken branches are not allocated, keeping the table for loops.
        validArr[idxE]  <= 1'b1;
        tagArr[idxE]    <= tagE;
        targetArr[idxE] <= PCTargetE_i;
        ctrArr[idxE]    <= WT;
      end
    end
  end

  bp_sat_counter #(.W(32)) branchCounter (
    .clk   (clk),
    .rst   (rst),
    .inc   (BranchE_i),
    .count (BranchCount_o)
  );

  bp_sat_counter #(.W(32)) mispredCounter (
    .clk   (clk),
    .rst   (rst),
    .inc   (MispredictE_o),
    .count (MispredCount_o)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed vectors push expected
// outputs, a negedge monitor pops and compares.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF_i;
  logic        PredictTakenF_o;
  logic [31:0] PredTargetF_o;
  logic        BranchE_i;
  logic        BranchTakenE_i;
  logic [31:0] PCE_i;
  logic [31:0] PCTargetE_i;
  logic        PredictTakenE_i;
  logic        MispredictE_o;
  logic [31:0] BranchCount_o;
  logic [31:0] MispredCount_o;

  logic        sRst;
  logic        sInc;
  logic [2:0]  sCount;

  int vectors = 0;
  int misses  = 0;

  typedef struct {
    string       name;
    logic        pred;
    logic [31:0] tgt;
    logic        mis;
    logic [31:0] bCnt;
    logic [31:0] mCnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  branch_predictor #(.DATA_WIDTH(32), .INDEX_BITS(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .PCF_i           (PCF_i),
    .PredictTakenF_o (PredictTakenF_o),
    .PredTargetF_o   (PredTargetF_o),
    .BranchE_i       (BranchE_i),
    .BranchTakenE_i  (BranchTakenE_i),
    .PCE_i           (PCE_i),
    .PCTargetE_i     (PCTargetE_i),
    .PredictTakenE_i (PredictTakenE_i),
    .MispredictE_o   (MispredictE_o),
    .BranchCount_o   (BranchCount_o),
    .MispredCount_o  (MispredCount_o)
  );

  // Narrow instance exercises the saturation path that 32 bits cannot reach.
  bp_sat_counter #(.W(3)) smallCounter (
    .clk   (clk),
    .rst   (sRst),
    .inc   (sInc),
    .count (sCount)
  );

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (PredictTakenF_o !== e.pred || PredTargetF_o !== e.tgt ||
          MispredictE_o !== e.mis || BranchCount_o !== e.bCnt ||
          MispredCount_o !== e.mCnt) begin
        misses++;
        $display("FAIL %s: got pred=%0b tgt=%h mis=%0b br=%0d mp=%0d, want pred=%0b tgt=%h mis=%0b br=%0d mp=%0d",
                 e.name, PredictTakenF_o, PredTargetF_o, MispredictE_o, BranchCount_o,
                 MispredCount_o, e.pred, e.tgt, e.mis, e.bCnt, e.mCnt);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic [31:0] pcf,
                      input logic br, input logic tk, input logic [31:0] pce,
                      input logic [31:0] tgt, input logic pe,
                      input logic ePred, input logic [31:0] eTgt, input logic eMis,
                      input logic [31:0] eB, input logic [31:0] eM);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    PCF_i           = pcf;
    BranchE_i       = br;
    BranchTakenE_i  = tk;
    PCE_i           = pce;
    PCTargetE_i     = tgt;
    PredictTakenE_i = pe;
    e.name = nm; e.pred = ePred; e.tgt = eTgt; e.mis = eMis; e.bCnt = eB; e.mCnt = eM;
    sb.push_back(e);
  endtask

  task automatic checkSmall(input string nm, input logic [2:0] want);
    vectors++;
    if (sCount !== want) begin
      misses++;
      $display("FAIL %s: got %0d want %0d", nm, sCount, want);
    end
  endtask

  initial begin
    rst = 1'b0; PCF_i = 32'h100; BranchE_i = 1'b0; BranchTakenE_i = 1'b0;
    PCE_i = '0; PCTargetE_i = '0; PredictTakenE_i = 1'b0;
    sRst = 1'b0; sInc = 1'b0;

    //      name                rst pcf       br tk pce       tgt       pe  pred tgt        mis br  mp
    step("rst_train_ignored",  0, 32'h100,  1, 1, 32'h100,  32'h80,   0,  0,   32'h0,     0,  0,  0);
    step("reset_state",        1, 32'h100,  0, 0, 32'h0,    32'h0,    0,  0,   32'h0,     0,  0,  0);
    step("first_taken_train",  1, 32'h100,  1, 1, 32'h100,  32'h80,   0,  0,   32'h0,     1,  0,  0);
    step("predict_after_alloc",1, 32'h100,  1, 0, 32'h100,  32'h0,    1,  1,   32'h80,    1,  1,  1);
    step("wt_to_wnt",          1, 32'h100,  0, 0, 32'h0,    32'h0,    0,  0,   32'h0,     0,  2,  2);
    step("wnt_nt_train",       1, 32'h100,  1, 0, 32'h100,  32'h0,    0,  0,   32'h0,     0,  2,  2);
    step("snt_taken_train",    1, 32'h100,  1, 1, 32'h100,  32'h84,   0,  0,   32'h0,     1,  3,  2);
    step("wnt_taken_train",    1, 32'h100,  1, 1, 32'h100,  32'h84,   0,  0,   32'h0,     1,  4,  3);
    step("retrain_taken",      1, 32'h100,  0, 0, 32'h0,    32'h0,    0,  1,   32'h84,    0,  5,  4);
    for (int i = 0; i < 4; i++)
      step("taken_run",        1, 32'h100,  1, 1, 32'h100,  32'h84,   1,  1,   32'h84,    0,  5 + i, 4);
    step("st_nt_train",        1, 32'h100,  1, 0, 32'h100,  32'h0,    1,  1,   32'h84,    1,  9,  4);
    step("st_sat_still_taken", 1, 32'h100,  0, 0, 32'h0,    32'h0,    0,  1,   32'h84,    0, 10,  5);
    step("alias_train",        1, 32'h100,  1, 1, 32'h200,  32'h40,   0,  1,   32'h84,    1, 10,  5);
    step("alias_evicted",      1, 32'h100,  0, 0, 32'h0,    32'h0,    0,  0,   32'h0,     0, 11,  6);
    step("alias_new",          1, 32'h200,  0, 0, 32'h0,    32'h0,    0,  1,   32'h40,    0, 11,  6);
    step("nt_miss_train",      1, 32'h104,  1, 0, 32'h104,  32'h0,    0,  0,   32'h0,     0, 11,  6);
    step("no_alloc_nt",        1, 32'h104,  0, 0, 32'h0,    32'h0,    0,  0,   32'h0,     0, 12,  6);
    step("same_cycle_read_old",1, 32'h300,  1, 1, 32'h300,  32'h1234, 0,  0,   32'h0,     1, 12,  6);
    step("same_cycle_next",    1, 32'h300,  0, 0, 32'h0,    32'h0,    0,  1,   32'h1234,  0, 13,  7);
    step("reset_gates_outputs",0, 32'h300,  1, 1, 32'h300,  32'h1234, 0,  0,   32'h0,     0, 13,  7);
    step("reset_midstream",    1, 32'h300,  0, 0, 32'h0,    32'h0,    0,  0,   32'h0,     0,  0,  0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      misses++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end

    @(posedge clk); #2;
    checkSmall("small_clear", 3'd0);
    sRst = 1'b1; sInc = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkSmall("small_count", 3'd3);
    repeat (6) @(posedge clk);
    #2;
    checkSmall("small_saturate", 3'd7);
    sRst = 1'b0;
    @(posedge clk); #2;
    checkSmall("small_clear_priority", 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
